// File: rtl/lsq_unit_if.sv
// Shared entry types and the data-memory store-write channel used by lsq_unit.
// The package lives here so the interface and the queue see one definition of the payload types.
package lsq_pkg;
  localparam int LSQ_SIZE = 8;

  typedef logic [31:0] address_t;
  typedef logic [31:0] memory_word_t;

  typedef struct packed {
    logic [31:0]  tag;
    address_t     address;
    memory_word_t value;
    logic [31:0]  color;
    logic         ready;
    logic         store;
    logic         valid;
  } lsq_entry_t;
endpackage

interface lsq_unit_if;
  logic                  mem_wr_valid;
  lsq_pkg::address_t     mem_wr_addr;
  lsq_pkg::memory_word_t mem_wr_data;
  logic                  mem_wr_ready;

  modport master (output mem_wr_valid, output mem_wr_addr, output mem_wr_data, input mem_wr_ready);
  modport slave  (input mem_wr_valid, input mem_wr_addr, input mem_wr_data, output mem_wr_ready);
endinterface

// File: rtl/lsq_unit.sv
// Load/store queue: in-order allocation at dispatch, memory-stage address/value updates,
// and in-order retirement with committed stores written out over a valid/ready channel.
module lsq_unit
  import lsq_pkg::*;
#(
  parameter int DEPTH = LSQ_SIZE,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_valid,
  input  logic [31:0]      alloc_tag,
  input  logic             alloc_store,
  output logic             alloc_ready,
  input  logic [31:0]      upd_ptr,
  input  lsq_entry_t       upd_entry,
  input  logic             commit_valid,
  input  logic [31:0]      commit_tag,
  output logic             commit_ready,
  lsq_unit_if.master       mem,
  input  logic             flush,
  output lsq_entry_t       lsq [DEPTH],
  output logic [PTR_W-1:0] lsq_head,
  output logic [PTR_W-1:0] lsq_tail,
  output logic [PTR_W:0]   count
);

  typedef enum logic {IDLE, ST_REQ} state_e;

  localparam lsq_entry_t EMPTY_ENTRY = '{tag: '1, default: '0};

  lsq_entry_t       lsq_q [DEPTH];
  lsq_entry_t       lsq_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [31:0]      color_q, color_d;
  state_e           state_q, state_d;
  logic             wr_valid_q, wr_valid_d;
  address_t         wr_addr_q, wr_addr_d;
  memory_word_t     wr_data_q, wr_data_d;
  logic             wr_orphan_q, wr_orphan_d;

  lsq_entry_t       head_e;
  logic             full, alloc_fire, pop, upd_hit;
  logic [PTR_W-1:0] upd_idx;
  logic             unused_upd;

  assign unused_upd = ^{upd_entry.tag, upd_entry.color, upd_entry.ready,
                        upd_entry.store, upd_entry.valid};

  always_comb begin
    state_d     = state_q;
    wr_valid_d  = wr_valid_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_orphan_d = wr_orphan_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    color_d     = color_q;
    lsq_d       = lsq_q;
    pop         = 1'b0;

    head_e       = lsq_q[head_q];
    full         = (count_q == (PTR_W+1)'(DEPTH));
    alloc_ready  = !full;
    alloc_fire   = alloc_valid && !full && !flush;
    commit_ready = (state_q == IDLE) && (count_q != '0) && (head_e.tag == commit_tag) &&
                   (head_e.store || head_e.ready);
    upd_idx      = PTR_W'(upd_ptr - 32'd1);
    upd_hit      = (upd_ptr != '0) && (upd_ptr <= 32'(DEPTH)) && lsq_q[upd_idx].valid;

    unique case (state_q)
      IDLE: begin
        if (commit_valid && commit_ready) begin
          if (!head_e.store) begin
            pop = 1'b1;
          end else if (head_e.ready || !flush) begin
            // A store committed in a flush cycle keeps its write; it just must not pop afterwards.
            state_d     = ST_REQ;
            wr_valid_d  = head_e.ready;
            wr_addr_d   = head_e.address;
            wr_data_d   = head_e.value;
            wr_orphan_d = flush;
          end
        end
      end
      ST_REQ: begin
        if (wr_valid_q) begin
          if (mem.mem_wr_ready) begin
            wr_valid_d  = 1'b0;
            wr_orphan_d = 1'b0;
            state_d     = IDLE;
            pop         = !wr_orphan_q && !flush;
          end else if (flush) begin
            wr_orphan_d = 1'b1;
          end
        end else if (flush || !head_e.valid) begin
          state_d = IDLE;
        end else if (head_e.ready) begin
          wr_valid_d = 1'b1;
          wr_addr_d  = head_e.address;
          wr_data_d  = head_e.value;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) lsq_d[i].valid = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (upd_hit) begin
        lsq_d[upd_idx].address = upd_entry.address;
        lsq_d[upd_idx].value   = upd_entry.value;
        lsq_d[upd_idx].ready   = 1'b1;
      end
      if (alloc_fire) begin
        lsq_d[tail_q] = '{tag: alloc_tag, address: '0, value: '0, color: color_q,
                          ready: 1'b0, store: alloc_store, valid: 1'b1};
        tail_d  = tail_q + 1'b1;
        color_d = color_q + 32'd1;
      end
      // Pop is applied last so it overrides a same-cycle update of the head slot.
      if (pop) begin
        lsq_d[head_q] = EMPTY_ENTRY;
        head_d        = head_q + 1'b1;
      end
      count_d = count_q + (PTR_W+1)'(alloc_fire) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) lsq_q[i] <= EMPTY_ENTRY;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      color_q     <= '0;
      state_q     <= IDLE;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_orphan_q <= 1'b0;
    end else begin
      lsq_q       <= lsq_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      color_q     <= color_d;
      state_q     <= state_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_orphan_q <= wr_orphan_d;
    end
  end

  assign lsq              = lsq_q;
  assign lsq_head         = head_q;
  assign lsq_tail         = tail_q;
  assign count            = count_q;
  assign mem.mem_wr_valid = wr_valid_q;
  assign mem.mem_wr_addr  = wr_addr_q;
  assign mem.mem_wr_data  = wr_data_q;

endmodule
